// File: rtl/uart_buffered.sv
// uart_buffered: FIFO-buffered UART for the FPG8 16-bit DATA bus, TX and RX queues.
// Optional even parity is compiled in with `define UART_PARITY_EN.

module uart_buffered_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    rd,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Callers guarantee wr only when there is room (or a pop this cycle) and rd only when non-empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd);
        cnt_d    = cnt_q + CNT_W'(wr) - CNT_W'(rd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = cnt_q;
endmodule

module uart_buffered #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [15:0] DATA,
    input  logic        uart_in_and_send,
    input  logic        uart_out,
    input  logic        uart_receive,
    input  logic        rx,
    output logic        tx,
    output logic        uart_done,
    output logic        tx_full,
    output logic        tx_busy,
    output logic        rx_overrun,
    output logic        frame_err,
    output logic        parity_err
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP, RX_WAIT
    } rx_state_e;

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic [CNT_W-1:0]     tx_count, rx_count;
    logic                 tx_wr, tx_pop, tx_empty;
    logic                 rx_wr, rx_pop, rx_empty, rx_full;
    logic                 data_unused;

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CNT_W'(FIFO_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_W'(FIFO_DEPTH));
    assign tx_wr    = uart_in_and_send && !tx_full;
    assign rx_pop   = uart_out && !rx_empty;
    assign data_unused = ^DATA[15:DATA_BITS];

    uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .wr(tx_wr), .wdata(DATA[DATA_BITS-1:0]),
        .rd(tx_pop), .rdata(tx_head), .count(tx_count)
    );

    // ---------------- TX ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [BAUD_W-1:0]    tx_baud_q, tx_baud_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d, tx_busy_q, tx_busy_d, tx_baud_end;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_baud_end = (tx_baud_q == BAUD_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        tx_pop     = 1'b0;
        if (tx_state_q != TX_IDLE) tx_baud_d = tx_baud_end ? '0 : tx_baud_q + 1'b1;
        case (tx_state_q)
            TX_IDLE:  tx_pop = !tx_empty;
            TX_START: if (tx_baud_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
            end
            TX_DATA: if (tx_baud_end) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 1'b1;
`ifdef UART_PARITY_EN
                if (tx_bit_q == BIT_LAST) tx_state_d = TX_PARITY;
            end
            TX_PARITY: if (tx_baud_end) begin
                tx_state_d = TX_STOP;
`else
                if (tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
`endif
            end
            TX_STOP: if (tx_baud_end) begin
                tx_state_d = TX_IDLE;
                tx_pop     = !tx_empty;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Popping always starts a frame, so back-to-back frames have no idle gap.
        if (tx_pop) begin
            tx_state_d = TX_START;
            tx_baud_d  = '0;
            tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (tx_state_q)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_shift_q[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_d = tx_par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
        tx_busy_d = !tx_empty || (tx_state_q != TX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

    // ---------------- RX ----------------
    rx_state_e            rx_state_q, rx_state_d;
    logic [BAUD_W-1:0]    rx_baud_q, rx_baud_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_push_q, rx_push_d, rx_baud_end;
    logic                 overrun_q, overrun_d, frame_err_q, frame_err_d;
`ifdef UART_PARITY_EN
    logic                 rx_par_q, rx_par_d, parity_err_q, parity_err_d;
`endif

    assign rx_baud_end = (rx_baud_q == BAUD_LAST);
    // A push into a full FIFO only lands if the CPU frees a slot on the same edge.
    assign rx_wr = rx_push_q && (!rx_full || rx_pop);

    uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .wr(rx_wr), .wdata(rx_shift_q),
        .rd(rx_pop), .rdata(rx_head), .count(rx_count)
    );

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_d   = 1'b0;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q | (rx_push_q & rx_full & ~rx_pop);
`ifdef UART_PARITY_EN
        rx_par_d     = rx_par_q;
        parity_err_d = parity_err_q;
`endif
        if (rx_state_q != RX_IDLE) rx_baud_d = rx_baud_end ? '0 : rx_baud_q + 1'b1;
        if (!uart_receive) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_baud_d  = '0;
                end
                RX_START: if (rx_baud_q == HALF_LAST) begin
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                end
                RX_DATA: if (rx_baud_end) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
`ifdef UART_PARITY_EN
                    if (rx_bit_q == BIT_LAST) rx_state_d = RX_PARITY;
                end
                RX_PARITY: if (rx_baud_end) begin
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
`else
                    if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
`endif
                end
                RX_STOP: if (rx_baud_end) begin
                    if (!rx_sync_q) begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT;
                    end else begin
                        rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
                        if ((^rx_shift_q) != rx_par_q) parity_err_d = 1'b1;
                        else rx_push_d = 1'b1;
`else
                        rx_push_d = 1'b1;
`endif
                    end
                end
                RX_WAIT: if (rx_sync_q) rx_state_d = RX_IDLE;
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q  <= RX_IDLE;
            rx_baud_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_push_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_push_q   <= rx_push_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef UART_PARITY_EN
            rx_par_q     <= rx_par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign uart_done  = !rx_empty;
    assign rx_overrun = overrun_q;
    assign frame_err  = frame_err_q;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    logic [15:0] rd_word;
    assign rd_word = rx_empty ? 16'h0000 : 16'(rx_head);
    assign DATA    = uart_out ? rd_word : {16{1'bz}};
endmodule

// File: tb/tb_uart_buffered.sv
// Self-checking bench for uart_buffered (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4):
// waveform/RX vector tables, hand sequences for corner cases, randomized traffic vs queue model.

module tb_uart_buffered;
    localparam int C  = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset, uart_in_and_send, uart_out, uart_receive, rx;
    wire  [15:0] DATA;
    logic [15:0] tb_data;
    logic        tb_drv;
    logic tx, uart_done, tx_full, tx_busy, rx_overrun, frame_err, parity_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic       mon_en;
    logic [7:0] dec_q[$];
    int         dec_t[$];

    assign DATA = tb_drv ? tb_data : {16{1'bz}};

    uart_buffered #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .DATA(DATA), .uart_in_and_send(uart_in_and_send),
        .uart_out(uart_out), .uart_receive(uart_receive), .rx(rx), .tx(tx),
        .uart_done(uart_done), .tx_full(tx_full), .tx_busy(tx_busy),
        .rx_overrun(rx_overrun), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   off;
        logic exp_tx;
        logic exp_busy;
    } wave_t;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        exp_done;
        logic [15:0] exp_read;
        logic        exp_ferr;
    } rxvec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tb_data = {8'h00, b};
        tb_drv = 1'b1;
        uart_in_and_send = 1'b1;
        tick();
        uart_in_and_send = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic rx_bit(input logic v);
        rx = v;
        repeat (C) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < DB; i++) rx_bit(b[i]);
        rx_bit(stop);
        if (!stop) begin
            rx = 1'b1;
            repeat (2 * C) tick();
        end
    endtask

    task automatic read_rx(output logic [15:0] d);
        uart_out = 1'b1;
        #1 d = DATA;
        tick();
        uart_out = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!uart_done && n < budget) begin
            tick();
            n++;
        end
        check(name, uart_done, 1'b1);
    endtask

    task automatic wait_tx_idle(input int budget, input string name);
        int n = 0;
        while (tx_busy && n < budget) begin
            tick();
            n++;
        end
        check(name, tx_busy, 1'b0);
    endtask

    // Line-level decoder: finds a start bit, samples each bit mid-period.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] b;
        int         st;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en && prev && !tx) begin
                st = cyc;
                repeat (C / 2) @(posedge clk);
                #2 check("tx_start_bit", tx, 1'b0);
                for (int i = 0; i < DB; i++) begin
                    repeat (C) @(posedge clk);
                    #2 b[i] = tx;
                end
                repeat (C) @(posedge clk);
                #2 check("tx_stop_bit", tx, 1'b1);
                dec_q.push_back(b);
                dec_t.push_back(st);
            end
            prev = tx;
        end
    end

    initial begin
        wave_t      wave[14];
        rxvec_t     rxv[4];
        logic [7:0] model_q[$];
        logic [7:0] ov[5];
        logic [15:0] d;
        logic [7:0] b;
        int         rel;

        // Expected line waveform for byte A5 pushed at edge N (offsets are edges after N).
        wave = '{'{1, 1'b1, 1'b1}, '{2, 1'b0, 1'b1}, '{5, 1'b0, 1'b1}, '{6, 1'b1, 1'b1},
                 '{10, 1'b0, 1'b1}, '{14, 1'b1, 1'b1}, '{18, 1'b0, 1'b1}, '{22, 1'b0, 1'b1},
                 '{26, 1'b1, 1'b1}, '{30, 1'b0, 1'b1}, '{34, 1'b1, 1'b1}, '{38, 1'b1, 1'b1},
                 '{41, 1'b1, 1'b1}, '{42, 1'b1, 1'b0}};
        rxv = '{'{8'h3C, 1'b1, 1'b1, 16'h003C, 1'b0},
                '{8'h00, 1'b1, 1'b1, 16'h0000, 1'b0},
                '{8'hFF, 1'b1, 1'b1, 16'h00FF, 1'b0},
                '{8'h81, 1'b0, 1'b0, 16'h0000, 1'b1}};
        ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        reset = 1'b1; uart_in_and_send = 1'b0; uart_out = 1'b0; uart_receive = 1'b0;
        rx = 1'b1; tb_drv = 1'b0; tb_data = 16'h0; mon_en = 1'b0;
        repeat (2) tick();
        check("reset_tx", tx, 1'b1);
        check("reset_done", uart_done, 1'b0);
        check("reset_full", tx_full, 1'b0);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_overrun", rx_overrun, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_perr", parity_err, 1'b0);
        reset = 1'b0;
        uart_receive = 1'b1;
        tick();
        mon_en = 1'b1;

        // Single TX, cycle-exact
        push_tx(8'hA5);
        rel = 0;
        foreach (wave[i]) begin
            while (rel < wave[i].off) begin
                tick();
                rel++;
            end
            check($sformatf("tx_wave_tx@%0d", wave[i].off), tx, wave[i].exp_tx);
            check($sformatf("tx_wave_busy@%0d", wave[i].off), tx_busy, wave[i].exp_busy);
        end
        repeat (4) tick();
        check("single_tx_count", dec_q.size(), 1);
        if (dec_q.size() > 0) check("single_tx_byte", dec_q.pop_front(), 8'hA5);
        dec_q.delete();
        dec_t.delete();

        // Back-to-back pushes; the 6th lands on a full FIFO and is dropped
        tb_drv = 1'b1;
        uart_in_and_send = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tb_data = 16'(i);
            tick();
            if (i == 4) check("b2b_full_after4", tx_full, 1'b0);
            if (i >= 5) check($sformatf("b2b_full_after%0d", i), tx_full, 1'b1);
        end
        uart_in_and_send = 1'b0;
        tb_drv = 1'b0;
        wait_tx_idle(400, "b2b_idle_timeout");
        repeat (4) tick();
        check("b2b_frames", dec_q.size(), 5);
        for (int i = 0; i < 5 && i < dec_q.size(); i++) begin
            check($sformatf("b2b_byte%0d", i), dec_q[i], 8'(i + 1));
            if (i > 0) check($sformatf("b2b_gap%0d", i), dec_t[i] - dec_t[i-1], (DB + 2) * C);
        end
        dec_q.delete();
        dec_t.delete();

        // RX vectors
        foreach (rxv[i]) begin
            send_frame(rxv[i].data, rxv[i].stop);
            if (rxv[i].exp_done) begin
                wait_done(12, $sformatf("rx%0d_done", i));
                read_rx(d);
                check($sformatf("rx%0d_data", i), d, rxv[i].exp_read);
                check($sformatf("rx%0d_done_after_pop", i), uart_done, 1'b0);
            end else begin
                repeat (12) tick();
                check($sformatf("rx%0d_no_push", i), uart_done, 1'b0);
            end
            check($sformatf("rx%0d_ferr", i), frame_err, rxv[i].exp_ferr);
        end

        // Overrun: five frames into a depth-4 FIFO, then a bad-stop frame that must not be stored
        for (int i = 0; i < 5; i++) begin
            send_frame(ov[i], 1'b1);
            if (i == 3) begin
                repeat (4) tick();
                check("ovr_not_yet", rx_overrun, 1'b0);
            end
        end
        repeat (4) tick();
        check("ovr_set", rx_overrun, 1'b1);
        send_frame(8'h99, 1'b0);
        for (int i = 0; i < 4; i++) begin
            read_rx(d);
            check($sformatf("ovr_read%0d", i), d, {8'h00, ov[i]});
        end
        check("ovr_drained", uart_done, 1'b0);
        read_rx(d);
        check("empty_read_zero", d, 16'h0000);

        // Receiver disabled mid-frame discards the partial byte
        rx_bit(1'b0);
        rx_bit(1'b1);
        uart_receive = 1'b0;
        rx_bit(1'b1);
        uart_receive = 1'b1;
        for (int i = 0; i < 7; i++) rx_bit(1'b1);
        repeat (12) tick();
        check("rx_abort_no_push", uart_done, 1'b0);

        // Randomized TX traffic vs queue model
        for (int i = 0; i < 8; i++) begin
            int n;
            repeat ($urandom_range(0, 50)) tick();
            n = 0;
            while (tx_full && n < 200) begin
                tick();
                n++;
            end
            check("rand_tx_full_timeout", tx_full, 1'b0);
            b = 8'($urandom);
            model_q.push_back(b);
            push_tx(b);
        end
        wait_tx_idle(1000, "rand_tx_idle_timeout");
        repeat (4) tick();
        check("rand_tx_count", dec_q.size(), model_q.size());
        while (dec_q.size() > 0 && model_q.size() > 0)
            check("rand_tx_byte", dec_q.pop_front(), model_q.pop_front());
        dec_q.delete();
        dec_t.delete();
        model_q.delete();

        // Randomized RX traffic vs queue model
        for (int i = 0; i < 6; i++) begin
            rx = 1'b1;
            repeat ($urandom_range(0, 6)) tick();
            b = 8'($urandom);
            model_q.push_back(b);
            send_frame(b, 1'b1);
            wait_done(12, "rand_rx_done");
            read_rx(d);
            check("rand_rx_byte", d, {8'h00, model_q.pop_front()});
        end

        // Reset mid-frame flushes both the line and the TX FIFO
        push_tx(8'h5A);
        push_tx(8'h5B);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("midreset_tx", tx, 1'b1);
        reset = 1'b0;
        tick();
        check("midreset_busy", tx_busy, 1'b0);
        check("midreset_full", tx_full, 1'b0);
        check("midreset_ferr_cleared", frame_err, 1'b0);
        check("midreset_ovr_cleared", rx_overrun, 1'b0);
        repeat (60) tick();
        check("midreset_tx_idle", tx, 1'b1);
        check("midreset_stays_idle", tx_busy, 1'b0);

        // One-cycle glitch on rx must be ignored
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (30) tick();
        check("glitch_no_push", uart_done, 1'b0);
        check("glitch_no_ferr", frame_err, 1'b0);
        check("glitch_no_perr", parity_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
